// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit: program-counter unit for the single-cycle RV32I core.
//
// Holds the fetch PC, produces the sequential next PC, and arbitrates trap and
// branch/jump redirects. A redirect that arrives while the pipeline is stalled
// is held in a one-entry pending buffer and is applied once stall drops.
// Misaligned redirect targets halt fetch until a trap recovers the unit.
//
// Optional feature macro: PC_UNIT_PERF_EN
//   defined   -> stall_cycles / redirect_count are saturating 32-bit counters
//   undefined -> both outputs tie to 0 and no counter flops exist
//
// Ports:
//   clk             in   rising-edge clock
//   reset           in   synchronous, active-high reset (highest priority)
//   stall           in   hold PC this cycle
//   redirect_valid  in   branch/jump taken
//   redirect_target in   branch/jump target            [WIDTH]
//   trap_valid      in   trap/exception entry
//   trap_vector     in   trap handler address          [WIDTH]
//   pc              out  current fetch PC (registered) [WIDTH]
//   pc_seq          out  pc + INCR (combinational)     [WIDTH]
//   fetch_valid     out  pc is a valid fetch address (registered)
//   flush           out  one-cycle pulse: pc was just redirected (registered)
//   misalign        out  sticky misaligned-target fault
//   fault_addr      out  offending target, captured on fault [WIDTH]
//   stall_cycles    out  RUN cycles spent stalled      [32]
//   redirect_count  out  applied redirects and traps   [32]
//
// Handshake: there is no back-pressure. trap_valid / redirect_valid are
// single-cycle strobes sampled on the rising edge; the resulting pc change is
// visible exactly one cycle later, together with a one-cycle flush pulse.
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter int                WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int                INCR         = 4,
  parameter int                ALIGN_BITS   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] trap_vector,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_seq,
  output logic             fetch_valid,
  output logic             flush,
  output logic             misalign,
  output logic [WIDTH-1:0] fault_addr,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      redirect_count
);

  // Mask of the low bits that must be zero in a legal target. ALIGN_BITS=0
  // yields an all-zero mask, which disables both the check and the trap
  // vector forcing.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'(1) << ALIGN_BITS) - 64'(1));

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic             flush_q, flush_d;
  logic             misalign_q, misalign_d;
  logic [WIDTH-1:0] fault_addr_q, fault_addr_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;

  // Candidate target for the redirect/pending path, which shares the
  // misalignment check.
  logic             take_target;
  logic [WIDTH-1:0] cand_target;
  logic [WIDTH-1:0] trap_pc;

  assign pc_seq  = pc_q + WIDTH'(INCR);
  assign trap_pc = trap_vector & ~ALIGN_MASK;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    flush_d       = 1'b0;
    misalign_d    = misalign_q;
    fault_addr_d  = fault_addr_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    take_target   = 1'b0;
    cand_target   = redirect_target;

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        if (trap_valid) begin
          pc_d         = trap_pc;
          flush_d      = 1'b1;
          pend_valid_d = 1'b0;
        end
      end

      ST_RUN: begin
        if (trap_valid) begin
          // Trap beats everything, including stall and a same-cycle redirect.
          pc_d         = trap_pc;
          flush_d      = 1'b1;
          pend_valid_d = 1'b0;
        end else if (redirect_valid && !stall) begin
          // A fresh redirect supersedes any pending one.
          take_target = 1'b1;
          cand_target = redirect_target;
        end else if (redirect_valid) begin
          // Stalled: remember only the newest redirect.
          pend_valid_d  = 1'b1;
          pend_target_d = redirect_target;
        end else if (pend_valid_q && !stall) begin
          take_target = 1'b1;
          cand_target = pend_target_q;
        end else if (!stall) begin
          pc_d = pc_seq;
        end

        if (take_target) begin
          pend_valid_d = 1'b0;
          if ((cand_target & ALIGN_MASK) != '0) begin
            // pc holds and no flush: fetch stops at the faulting point.
            fault_addr_d = cand_target;
            misalign_d   = 1'b1;
            state_d      = ST_HALT;
          end else begin
            pc_d    = cand_target;
            flush_d = 1'b1;
          end
        end
      end

      ST_HALT: begin
        pend_valid_d = 1'b0;
        if (trap_valid) begin
          pc_d       = trap_pc;
          flush_d    = 1'b1;
          misalign_d = 1'b0;
          state_d    = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    fetch_valid_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
      fault_addr_q  <= '0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      misalign_q    <= misalign_d;
      fault_addr_q  <= fault_addr_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign flush       = flush_q;
  assign misalign    = misalign_q;
  assign fault_addr  = fault_addr_q;

`ifdef PC_UNIT_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] redirect_count_q, redirect_count_d;

  // flush_d is high exactly when a trap or redirect is applied this cycle.
  always_comb begin
    stall_cycles_d   = stall_cycles_q;
    redirect_count_d = redirect_count_q;
    if ((state_q == ST_RUN) && stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (flush_d && (redirect_count_q != 32'hFFFF_FFFF)) begin
      redirect_count_d = redirect_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q   <= '0;
      redirect_count_q <= '0;
    end else begin
      stall_cycles_q   <= stall_cycles_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign stall_cycles   = stall_cycles_q;
  assign redirect_count = redirect_count_q;
`else
  assign stall_cycles   = 32'd0;
  assign redirect_count = 32'd0;
`endif

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the single-cycle RV32I core; supersedes the plain PC register.
- Holds the fetch PC and computes the sequential next PC.
- Arbitrates trap and branch/jump redirects, and buffers a redirect that arrives during a stall.
- Detects misaligned targets and halts fetch until a trap recovers it. Sits between execute/trap logic and instruction memory.

Parameters:
- WIDTH, 32, PC width in bits.
- RESET_VECTOR, 0, PC value loaded on reset (WIDTH bits).
- INCR, 4, sequential increment in bytes.
- ALIGN_BITS, 2, number of low target bits that must be zero; 0 disables the misalignment check.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC this cycle.
- redirect_valid  in  1  branch/jump taken.
- redirect_target  in  WIDTH  branch/jump target.
- trap_valid  in  1  trap/exception entry.
- trap_vector  in  WIDTH  trap handler address.
- pc  out  WIDTH  current fetch PC (registered).
- pc_seq  out  WIDTH  pc + INCR (combinational).
- fetch_valid  out  1  pc is a valid fetch address.
- flush  out  1  registered one-cycle pulse: pc was just redirected.
- misalign  out  1  sticky misaligned-target fault.
- fault_addr  out  WIDTH  offending target, captured on fault.
- stall_cycles  out  32  performance counter (see Optional Feature).
- redirect_count  out  32  performance counter (see Optional Feature).

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high. Reset has priority over all other inputs.
- Reset values: pc=RESET_VECTOR; state=BOOT; fetch_valid=0; flush=0; misalign=0; fault_addr=0; pending buffer empty; counters=0.
- States:
  - BOOT: lasts 1 cycle, fetch_valid=0.
  - RUN: fetch_valid=1.
  - HALT: fetch_valid=0.
- BOOT transitions:
  - Always goes to RUN next cycle.
  - pc holds unless trap_valid=1, in which case the trap is applied.
  - redirect_valid is ignored in BOOT.
- RUN, next-pc priority (highest first):
  1. trap_valid: pc<=trap_vector with the low ALIGN_BITS forced to 0. Applies even when stall=1. Clears the pending buffer.
  2. redirect_valid with stall=0: pc<=redirect_target. Clears the pending buffer.
  3. redirect_valid with stall=1: target is latched into the pending buffer and pc holds. A later redirect overwrites an older pending one.
  4. Pending buffer full with stall=0: pc<=pending target; buffer cleared.
  5. stall=1: pc holds.
  6. Otherwise: pc<=pc+INCR.
- Wrap-around: pc+INCR is modulo 2^WIDTH. At pc=2^WIDTH-INCR, the next pc is 0 with no flag raised.
- flush: set to 1 in the cycle after any applied trap or redirect (i.e. the same cycle the new pc is visible), otherwise 0. Latching a redirect into the pending buffer does not assert flush.
- Misalignment:
  - Checked when a redirect or pending target is applied, only if ALIGN_BITS>0.
  - Fault condition: any of the low ALIGN_BITS bits of the target is nonzero.
  - On fault: pc holds; fault_addr<=target; misalign<=1; state->HALT; flush not asserted.
- HALT:
  - pc holds; redirects and stall are ignored; pending buffer is cleared on entry.
  - Exit only on trap_valid: apply the trap vector, misalign<=0, state->RUN, flush=1 next cycle.
- Simultaneous events:
  - trap and redirect in the same cycle: trap wins; the redirect is dropped.
  - Redirect arriving in the same cycle that stall falls, with a pending entry present: the new redirect wins.
- Reset mid-operation: any state and the pending buffer are discarded; reset values apply next cycle.
- Latency: every pc change is visible exactly 1 cycle after the causing input. pc_seq has 0-cycle latency.

Optional Feature:
- Macro: PC_UNIT_PERF_EN.
- Defined:
  - stall_cycles increments every RUN cycle with stall=1.
  - redirect_count increments on every applied redirect or trap.
  - Both counters saturate at 2^32-1 and reset to 0.
- Not defined: both outputs are constant 0 and no counter flops are inferred.

Test Plan:
- Reset then idle, WIDTH=32, RESET_VECTOR=0x100 -> BOOT cycle at pc=0x100 with fetch_valid=0; then 0x100, 0x104, 0x108 with fetch_valid=1.
- Redirect to 0x200 with stall=0 at pc=0x108 -> next pc=0x200, flush=1 for one cycle, then 0x204.
- stall=1 for 3 cycles; redirect 0x300 then redirect 0x340 during the stall -> pc holds, flush=0; stall falls -> pc=0x340 with flush=1, and 0x300 is never fetched.
- Redirect to 0x302 -> pc holds, misalign=1, fault_addr=0x302, fetch_valid=0; trap_vector 0x81 -> pc=0x80, misalign=0, RUN.
- Simultaneous trap 0x80 and redirect 0x400 while stall=1 -> pc=0x80, pending cleared, and 0x400 is never applied after stall falls.
- pc=0xFFFFFFFC with no stall -> next pc=0x0. With PC_UNIT_PERF_EN, 5 stall cycles then 2 redirects -> stall_cycles=5, redirect_count=2.
